// File: rtl/fpcdiv_if.sv
// rtl/fpcdiv_if.sv - operand/result handshake bundle for the complex fixed-point divider
interface fpcdiv_if #(
    parameter int n = 32
);
    logic         recv_val;
    logic         recv_rdy;
    logic [n-1:0] ar;
    logic [n-1:0] ac;
    logic [n-1:0] br;
    logic [n-1:0] bc;
    logic         send_val;
    logic         send_rdy;
    logic [n-1:0] cr;
    logic [n-1:0] cc;
    logic         div0;

    modport master (
        output recv_val, ar, ac, br, bc, send_rdy,
        input  recv_rdy, send_val, cr, cc, div0
    );

    modport slave (
        input  recv_val, ar, ac, br, bc, send_rdy,
        output recv_rdy, send_val, cr, cc, div0
    );
endinterface

// File: rtl/fpcdiv.sv
// rtl/fpcdiv.sv - sequential complex division c = a / b in signed Q(n-d).d fixed point
module fpcdiv #(
    parameter int n = 32,
    parameter int d = 16
) (
    input  logic      clk,
    input  logic      reset,
    fpcdiv_if.slave   bus
);

    localparam int CW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [2:0] {IDLE, MUL, SUM, DIV, DONE} state_t;

    state_t state_q, state_d;

    // iteration counters: bit within current product/quotient, and which one
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;

    // operands captured on the accept edge
    logic [n-1:0]  ar_q, ac_q, br_q, bc_q;

    // shared shift-add multiplier working on magnitudes
    logic [2*n-1:0] mc_q;
    logic [2*n-1:0] acc_q;
    logic [n-1:0]   mp_q;
    logic           neg_q;
    logic [n-1:0]   prod_q [6];

    // shared restoring divider; den is kept as a magnitude plus sign
    logic [n-1:0]  den_mag_q;
    logic          den_neg_q;
    logic          den_zero_q;
    logic [n-1:0]  numc_q;
    logic [n-1:0]  rem_q;
    logic [n-1:0]  dv_q;
    logic [n-1:0]  quo_q;
    logic          qneg_q;

    // registered results
    logic [n-1:0]  cr_q, cc_q;
    logic          div0_q;

    function automatic logic [n-1:0] mag(input logic [n-1:0] x);
        return x[n-1] ? -x : x;
    endfunction

    logic           last_bit;
    logic [n-1:0]   op_a, op_b;
    logic [2*n-1:0] acc_step;
    logic [2*n-1:0] prod_full;
    logic [n-1:0]   den_w, numr_w, numc_w;
    logic [n-1:0]   numr_mag, numc_mag;
    logic [n:0]     rem_sh;
    logic           ge;
    logic [n-1:0]   rem_nx;
    logic [n-1:0]   quo_nx;
    logic [n-1:0]   q_res;

    assign last_bit = (cnt_q == CW'(n - 1));

    // operand pair for the product that follows the current one
    always_comb begin
        op_a = br_q;
        op_b = br_q;
        case (idx_q)
            3'd0:    begin op_a = bc_q; op_b = bc_q; end
            3'd1:    begin op_a = ar_q; op_b = br_q; end
            3'd2:    begin op_a = ac_q; op_b = bc_q; end
            3'd3:    begin op_a = ac_q; op_b = br_q; end
            3'd4:    begin op_a = ar_q; op_b = bc_q; end
            default: begin op_a = br_q; op_b = br_q; end
        endcase
    end

    // multiplier step, product sign fix-up, sums and divider step
    always_comb begin
        acc_step  = acc_q + (mp_q[0] ? mc_q : '0);
        prod_full = neg_q ? -acc_step : acc_step;

        den_w     = prod_q[0] + prod_q[1];
        numr_w    = prod_q[2] + prod_q[3];
        numc_w    = prod_q[4] - prod_q[5];
        numr_mag  = mag(numr_w);
        numc_mag  = mag(numc_q);

        rem_sh    = {rem_q, dv_q[n-1]};
        ge        = (rem_sh >= {1'b0, den_mag_q});
        rem_nx    = rem_sh[n-1:0] - (ge ? den_mag_q : '0);
        quo_nx    = (quo_q << 1) | {{(n-1){1'b0}}, ge};
        q_res     = den_zero_q ? '0 : (qneg_q ? -quo_nx : quo_nx);
    end

    // state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next-state and handshake outputs
    always_comb begin
        state_d      = state_q;
        bus.recv_rdy = 1'b0;
        bus.send_val = 1'b0;
        case (state_q)
            IDLE: begin
                bus.recv_rdy = 1'b1;
                if (bus.recv_val) state_d = MUL;
            end
            MUL: begin
                if (last_bit && idx_q == 3'd5) state_d = SUM;
            end
            SUM: begin
                state_d = DIV;
            end
            DIV: begin
                if (last_bit && idx_q == 3'd1) state_d = DONE;
            end
            DONE: begin
                bus.send_val = 1'b1;
                if (bus.send_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // datapath: operand capture, multiply, sum, divide and result hold
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            ar_q       <= '0;
            ac_q       <= '0;
            br_q       <= '0;
            bc_q       <= '0;
            mc_q       <= '0;
            acc_q      <= '0;
            mp_q       <= '0;
            neg_q      <= 1'b0;
            for (int i = 0; i < 6; i++) prod_q[i] <= '0;
            den_mag_q  <= '0;
            den_neg_q  <= 1'b0;
            den_zero_q <= 1'b0;
            numc_q     <= '0;
            rem_q      <= '0;
            dv_q       <= '0;
            quo_q      <= '0;
            qneg_q     <= 1'b0;
            cr_q       <= '0;
            cc_q       <= '0;
            div0_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.recv_val) begin
                        ar_q  <= bus.ar;
                        ac_q  <= bus.ac;
                        br_q  <= bus.br;
                        bc_q  <= bus.bc;
                        cnt_q <= '0;
                        idx_q <= '0;
                        acc_q <= '0;
                        // first product is br*br, always non-negative
                        mc_q  <= {{n{1'b0}}, mag(bus.br)};
                        mp_q  <= mag(bus.br);
                        neg_q <= 1'b0;
                    end
                end
                MUL: begin
                    if (last_bit) begin
                        prod_q[idx_q] <= n'(prod_full >> d);
                        cnt_q <= '0;
                        idx_q <= idx_q + 3'd1;
                        acc_q <= '0;
                        mc_q  <= {{n{1'b0}}, mag(op_a)};
                        mp_q  <= mag(op_b);
                        neg_q <= op_a[n-1] ^ op_b[n-1];
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        acc_q <= acc_step;
                        mc_q  <= mc_q << 1;
                        mp_q  <= mp_q >> 1;
                    end
                end
                SUM: begin
                    den_mag_q  <= mag(den_w);
                    den_neg_q  <= den_w[n-1];
                    den_zero_q <= (den_w == '0);
                    numc_q     <= numc_w;
                    // high half of |numr|<<d seeds the remainder, low half is shifted in
                    rem_q      <= numr_mag >> (n - d);
                    dv_q       <= numr_mag << d;
                    quo_q      <= '0;
                    qneg_q     <= numr_w[n-1] ^ den_w[n-1];
                    cnt_q      <= '0;
                    idx_q      <= '0;
                end
                DIV: begin
                    if (last_bit) begin
                        cnt_q <= '0;
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'd0) begin
                            cr_q   <= q_res;
                            rem_q  <= numc_mag >> (n - d);
                            dv_q   <= numc_mag << d;
                            quo_q  <= '0;
                            qneg_q <= numc_q[n-1] ^ den_neg_q;
                        end else begin
                            cc_q   <= q_res;
                            div0_q <= den_zero_q;
                        end
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                        rem_q <= rem_nx;
                        dv_q  <= dv_q << 1;
                        quo_q <= quo_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.cr   = cr_q;
    assign bus.cc   = cc_q;
    assign bus.div0 = div0_q;

endmodule

// File: tb/tb_fpcdiv.sv
// tb/tb_fpcdiv.sv - directed self-checking bench for fpcdiv with a reference model
module tb_fpcdiv;

    localparam int N   = 32;
    localparam int D   = 16;
    localparam int LAT = 8 * N + 1;

    typedef struct packed {
        logic [31:0] cr;
        logic [31:0] cc;
        logic        div0;
    } res_t;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   acc_cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   delivered = 0;
    res_t exp_q[$];
    res_t last_res;
    res_t m;
    logic exp_sv;

    fpcdiv_if #(.n(N)) bus ();

    fpcdiv #(.n(N), .d(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // reference: fixed-point product, truncated to n bits after >>> d
    function automatic logic [31:0] pmul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'(signed'(a)) * longint'(signed'(b));
        p = p >>> D;
        return p[31:0];
    endfunction

    // reference: trunc-toward-zero of (num * 2^d) / den on magnitudes
    function automatic logic [31:0] qdiv(input logic [31:0] num, input logic [31:0] den);
        longint sn, sd;
        longint unsigned un, ud, q;
        logic [31:0] lo;
        sn = longint'(signed'(num));
        sd = longint'(signed'(den));
        un = (sn < 0) ? longint'(-sn) : longint'(sn);
        ud = (sd < 0) ? longint'(-sd) : longint'(sd);
        q  = (un << D) / ud;
        lo = q[31:0];
        return (num[31] ^ den[31]) ? -lo : lo;
    endfunction

    function automatic res_t model(input logic [31:0] ar, input logic [31:0] ac,
                                   input logic [31:0] br, input logic [31:0] bc);
        res_t r;
        logic [31:0] den, numr, numc;
        den  = pmul(br, br) + pmul(bc, bc);
        numr = pmul(ar, br) + pmul(ac, bc);
        numc = pmul(ac, br) - pmul(ar, bc);
        if (den == 32'd0) begin
            r.cr = 32'd0; r.cc = 32'd0; r.div0 = 1'b1;
        end else begin
            r.cr = qdiv(numr, den); r.cc = qdiv(numc, den); r.div0 = 1'b0;
        end
        return r;
    endfunction

    // compare process: handshake timing every cycle, result whenever send_val is up
    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("recv_rdy", {63'd0, bus.recv_rdy}, {63'd0, exp_q.size() == 0});
            exp_sv = (exp_q.size() > 0) && (cyc - acc_cyc >= LAT);
            chk("send_val", {63'd0, bus.send_val}, {63'd0, exp_sv});
            if (bus.send_val && exp_q.size() > 0) begin
                chk("cr",   {32'd0, bus.cr}, {32'd0, exp_q[0].cr});
                chk("cc",   {32'd0, bus.cc}, {32'd0, exp_q[0].cc});
                chk("div0", {63'd0, bus.div0}, {63'd0, exp_q[0].div0});
            end
            if (reset) begin
                exp_q.delete();
            end else begin
                if (bus.send_val && bus.send_rdy && exp_q.size() > 0) begin
                    last_res = '{cr: bus.cr, cc: bus.cc, div0: bus.div0};
                    void'(exp_q.pop_front());
                    delivered++;
                end
                if (bus.recv_val && bus.recv_rdy) begin
                    exp_q.push_back(model(bus.ar, bus.ac, bus.br, bus.bc));
                    acc_cyc = cyc + 1;
                end
            end
        end
    end

    task automatic set_ops(input logic [31:0] ar, input logic [31:0] ac,
                           input logic [31:0] br, input logic [31:0] bc);
        bus.ar = ar; bus.ac = ac; bus.br = br; bus.bc = bc;
    endtask

    task automatic send_op(input logic [31:0] ar, input logic [31:0] ac,
                           input logic [31:0] br, input logic [31:0] bc);
        int k;
        set_ops(ar, ac, br, bc);
        bus.recv_val = 1'b1;
        k = 0;
        while (!bus.recv_rdy && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.recv_rdy) chk("accept_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        bus.recv_val = 1'b0;
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        while (!bus.send_val && k < LAT + 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.send_val) chk("result_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_op(input logic [31:0] ar, input logic [31:0] ac,
                          input logic [31:0] br, input logic [31:0] bc);
        bus.send_rdy = 1'b1;
        send_op(ar, ac, br, bc);
        wait_valid();
        @(posedge clk); #1;
    endtask

    task automatic chk_last(input string nm, input res_t r);
        chk({nm, "_cr"},   {32'd0, last_res.cr}, {32'd0, r.cr});
        chk({nm, "_cc"},   {32'd0, last_res.cc}, {32'd0, r.cc});
        chk({nm, "_div0"}, {63'd0, last_res.div0}, {63'd0, r.div0});
    endtask

    initial begin
        reset        = 1'b1;
        bus.recv_val = 1'b0;
        bus.send_rdy = 1'b1;
        set_ops(32'd0, 32'd0, 32'd0, 32'd0);
        last_res     = '0;

        // model pinned by hand-computed spec vectors
        m = model(32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0);
        chk("model_identity", {31'd0, m}, {31'd0, 32'h0001_0000, 32'h0, 1'b0});
        m = model(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000);
        chk("model_conj", {31'd0, m}, {31'd0, 32'h0, 32'h0001_0000, 1'b0});
        m = model(32'h0003_0000, 32'h0004_0000, 32'h0, 32'h0002_0000);
        chk("model_mixed", {31'd0, m}, {31'd0, 32'h0002_0000, 32'hFFFE_8000, 1'b0});
        m = model(32'h0005_0000, 32'h0005_0000, 32'h0, 32'h0);
        chk("model_div0", {31'd0, m}, {31'd0, 32'h0, 32'h0, 1'b1});

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_recv_rdy", {63'd0, bus.recv_rdy}, 64'd1);
        chk("rst_send_val", {63'd0, bus.send_val}, 64'd0);
        chk("rst_cr",       {32'd0, bus.cr}, 64'd0);
        chk("rst_cc",       {32'd0, bus.cc}, 64'd0);
        chk("rst_div0",     {63'd0, bus.div0}, 64'd0);

        run_op(32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0);
        chk_last("identity", '{cr: 32'h0001_0000, cc: 32'h0, div0: 1'b0});
        run_op(32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000);
        chk_last("conj", '{cr: 32'h0, cc: 32'h0001_0000, div0: 1'b0});
        run_op(32'h0003_0000, 32'h0004_0000, 32'h0, 32'h0002_0000);
        chk_last("mixed", '{cr: 32'h0002_0000, cc: 32'hFFFE_8000, div0: 1'b0});
        run_op(32'h0005_0000, 32'h0005_0000, 32'h0, 32'h0);
        chk_last("div0", '{cr: 32'h0, cc: 32'h0, div0: 1'b1});

        // fractional operands with a truncated quotient
        run_op(32'h0001_8000, 32'hFFFD_C000, 32'h0000_8000, 32'h0000_C000);
        // large divisor whose |b|^2 wraps negative
        run_op(32'h03E8_0000, 32'h0, 32'h00C8_0000, 32'h0);

        // backpressure with busy-side operand churn, then release with recv_val held
        bus.send_rdy = 1'b0;
        send_op(32'h0002_0000, 32'hFFFF_0000, 32'h0001_0000, 32'h0001_0000);
        wait_valid();
        bus.recv_val = 1'b1;
        for (int i = 0; i < 10; i++) begin
            set_ops($urandom, $urandom, $urandom, $urandom);
            @(posedge clk); #1;
        end
        chk("bp_recv_rdy", {63'd0, bus.recv_rdy}, 64'd0);
        chk("bp_send_val", {63'd0, bus.send_val}, 64'd1);
        set_ops(32'hFFFE_0000, 32'h0003_0000, 32'h0002_0000, 32'hFFFF_0000);
        bus.send_rdy = 1'b1;
        @(posedge clk); #1;
        chk("bp_after_recv_rdy", {63'd0, bus.recv_rdy}, 64'd1);
        chk("bp_after_send_val", {63'd0, bus.send_val}, 64'd0);
        chk_last("bp", '{cr: 32'h0000_8000, cc: 32'hFFFE_8000, div0: 1'b0});
        @(posedge clk); #1;
        bus.recv_val = 1'b0;
        wait_valid();
        @(posedge clk); #1;

        // reset 100 cycles into the multiply phase
        send_op(32'h0007_0000, 32'h0002_0000, 32'h0003_0000, 32'h0001_0000);
        repeat (100) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midrst_send_val", {63'd0, bus.send_val}, 64'd0);
        chk("midrst_recv_rdy", {63'd0, bus.recv_rdy}, 64'd1);
        chk("midrst_cr",       {32'd0, bus.cr}, 64'd0);
        run_op(32'h0003_0000, 32'h0004_0000, 32'h0, 32'h0002_0000);
        chk_last("post_rst", '{cr: 32'h0002_0000, cc: 32'hFFFE_8000, div0: 1'b0});

        repeat (5) @(posedge clk);
        #1;
        chk("delivered", delivered, 64'd9);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
